// File: rtl/game_menu_pkg.sv
// ---------------------------------------------------------------------------
// game_menu_pkg
// Purpose : shared types, encodings and small helper functions for the game
//           menu controller (state enum, vgaMUX encodings, wrap/saturate steps).
// Ports   : none (package).
// Build   : optional feature macro MENU_IDLE_TIMEOUT_EN is consumed by
//           game_menu_ctrl, not by this package.
// ---------------------------------------------------------------------------
package game_menu_pkg;

  // Life cycle of the controller: browse, hold cores in reset, run, tear down.
  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    EXIT   = 2'd3
  } state_e;

  // vgaMUX encodings: 0 shows the menu background, game g shows on g+1.
  localparam logic [1:0] VGAMUX_MENU  = 2'd0;
  localparam logic [1:0] VGAMUX_GAME0 = 2'd1;

  // Menu cursor step: up decrements, down increments, both wrap; up+down cancel.
  function automatic logic [1:0] choice_step(input logic [1:0] cur,
                                             input logic [1:0] last,
                                             input logic       up,
                                             input logic       down);
    logic [1:0] res;
    res = cur;
    if (up && !down) begin
      if (cur == 2'd0) begin
        res = last;
      end else begin
        res = cur - 2'd1;
      end
    end else if (down && !up) begin
      if (cur == last) begin
        res = 2'd0;
      end else begin
        res = cur + 2'd1;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Speed step: left decrements, right increments, both saturate; left+right cancel.
  function automatic logic [3:0] speed_step(input logic [3:0] cur,
                                            input logic [3:0] min_v,
                                            input logic [3:0] max_v,
                                            input logic       left,
                                            input logic       right);
    logic [3:0] res;
    res = cur;
    if (left && !right) begin
      if (cur <= min_v) begin
        res = min_v;
      end else begin
        res = cur - 4'd1;
      end
    end else if (right && !left) begin
      if (cur >= max_v) begin
        res = max_v;
      end else begin
        res = cur + 4'd1;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/game_menu_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_menu_ctrl_if
// Purpose : bundles the debounced key levels coming from the game datapath and
//           the select/reset outputs going back to it.
// Signals : button_up/down/left/right, start_btn, exit   (datapath -> ctrl)
//           vgaMUX[1:0], choice[1:0], speedcontrol[3:0],
//           gamein_rst, game_active                       (ctrl -> datapath)
// Modports: master = the menu controller, slave = the datapath side.
// ---------------------------------------------------------------------------
interface game_menu_ctrl_if;
  logic       button_up;
  logic       button_down;
  logic       button_left;
  logic       button_right;
  logic       start_btn;
  logic       exit;
  logic [1:0] vgaMUX;
  logic [1:0] choice;
  logic [3:0] speedcontrol;
  logic       gamein_rst;
  logic       game_active;

  modport master (
    input  button_up, button_down, button_left, button_right, start_btn, exit,
    output vgaMUX, choice, speedcontrol, gamein_rst, game_active
  );

  modport slave (
    output button_up, button_down, button_left, button_right, start_btn, exit,
    input  vgaMUX, choice, speedcontrol, gamein_rst, game_active
  );
endinterface

// File: rtl/edge_rise.sv
// ---------------------------------------------------------------------------
// edge_rise
// Purpose : single-bit rising-edge detector; a held level yields one event.
// Ports   : clk    in  clock
//           rst_n  in  asynchronous active-low reset (history clears to 0)
//           level  in  debounced level
//           ev     out one-cycle pulse, level & ~previous level
// ---------------------------------------------------------------------------
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic ev
);

  logic level_q_r;

  // Level history used to spot the low-to-high transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q_r <= 1'b0;
    end else begin
      level_q_r <= level;
    end
  end

  assign ev = level & ~level_q_r;

endmodule

// File: rtl/game_menu_ctrl.sv
// ---------------------------------------------------------------------------
// game_menu_ctrl
// Purpose : menu -> launch -> play -> exit sequencer driving the game datapath
//           select inputs (vgaMUX, choice, speedcontrol, gamein_rst).
// Ports   : sys_clk    in  system clock
//           sys_rst_n  in  asynchronous active-low reset
//           bus        game_menu_ctrl_if.master (key levels in, selects out)
// Build   : define MENU_IDLE_TIMEOUT_EN to return the menu cursor to entry 0
//           after IDLE_CYCLES cycles without a key event while in MENU.
// ---------------------------------------------------------------------------
module game_menu_ctrl
  import game_menu_pkg::*;
#(
  parameter int NUM_GAMES   = 2,
  parameter int RST_CYCLES  = 16,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 15,
`ifdef MENU_IDLE_TIMEOUT_EN
  parameter int SPEED_DEF   = 4,
  parameter int IDLE_CYCLES = 50000000
`else
  parameter int SPEED_DEF   = 4
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  game_menu_ctrl_if.master bus
);

  localparam logic [1:0] CHOICE_LAST = 2'(NUM_GAMES - 1);
  localparam logic [3:0] SPD_MIN     = 4'(SPEED_MIN);
  localparam logic [3:0] SPD_MAX     = 4'(SPEED_MAX);
  localparam logic [3:0] SPD_DEF     = 4'(SPEED_DEF);
  localparam int         LC_W        = $clog2(RST_CYCLES + 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(RST_CYCLES - 1);

  state_e            state_r,      state_nxt_s;
  logic [1:0]        game_r,       game_nxt_s;
  logic [1:0]        choice_r,     choice_nxt_s;
  logic [3:0]        speed_r,      speed_nxt_s;
  logic [LC_W-1:0]   launch_cnt_r, launch_cnt_nxt_s;
  logic [1:0]        vga_mux_r,    vga_mux_nxt_s;
  logic              gamein_rst_r, gamein_rst_nxt_s;
  logic              game_active_r, game_active_nxt_s;

  logic up_ev_s, down_ev_s, left_ev_s, right_ev_s, start_ev_s;

`ifdef MENU_IDLE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_nxt_s;
  logic              any_ev_s;
  assign any_ev_s = up_ev_s | down_ev_s | left_ev_s | right_ev_s | start_ev_s;
`endif

  edge_rise u_up    (.clk(sys_clk), .rst_n(sys_rst_n), .level(bus.button_up),    .ev(up_ev_s));
  edge_rise u_down  (.clk(sys_clk), .rst_n(sys_rst_n), .level(bus.button_down),  .ev(down_ev_s));
  edge_rise u_left  (.clk(sys_clk), .rst_n(sys_rst_n), .level(bus.button_left),  .ev(left_ev_s));
  edge_rise u_right (.clk(sys_clk), .rst_n(sys_rst_n), .level(bus.button_right), .ev(right_ev_s));
  edge_rise u_start (.clk(sys_clk), .rst_n(sys_rst_n), .level(bus.start_btn),    .ev(start_ev_s));

  // Next-state, menu registers and next-output values.
  always_comb begin
    state_nxt_s      = state_r;
    game_nxt_s       = game_r;
    choice_nxt_s     = choice_r;
    speed_nxt_s      = speed_r;
    launch_cnt_nxt_s = launch_cnt_r;
`ifdef MENU_IDLE_TIMEOUT_EN
    idle_cnt_nxt_s   = '0;
`endif
    case (state_r)
      MENU: begin
        speed_nxt_s = speed_step(speed_r, SPD_MIN, SPD_MAX, left_ev_s, right_ev_s);
        if (start_ev_s) begin
          // Launching wins over cursor movement seen on the same cycle.
          state_nxt_s      = LAUNCH;
          game_nxt_s       = choice_r;
          launch_cnt_nxt_s = '0;
        end else begin
          choice_nxt_s = choice_step(choice_r, CHOICE_LAST, up_ev_s, down_ev_s);
`ifdef MENU_IDLE_TIMEOUT_EN
          if (any_ev_s) begin
            idle_cnt_nxt_s = '0;
          end else if (idle_cnt_r == IDLE_LAST) begin
            choice_nxt_s   = 2'd0;
            idle_cnt_nxt_s = '0;
          end else begin
            idle_cnt_nxt_s = idle_cnt_r + 1'b1;
          end
`endif
        end
      end
      LAUNCH: begin
        if (bus.exit) begin
          state_nxt_s = MENU;
        end else if (launch_cnt_r == LC_LAST) begin
          state_nxt_s = PLAY;
        end else begin
          launch_cnt_nxt_s = launch_cnt_r + 1'b1;
        end
      end
      PLAY: begin
        if (bus.exit) begin
          state_nxt_s = EXIT;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      EXIT: begin
        state_nxt_s = MENU;
      end
      default: begin
        state_nxt_s = MENU;
      end
    endcase

    // Outputs are derived from the state being entered so they register in step.
    if ((state_nxt_s == LAUNCH) || (state_nxt_s == PLAY)) begin
      vga_mux_nxt_s = game_nxt_s + VGAMUX_GAME0;
    end else begin
      vga_mux_nxt_s = VGAMUX_MENU;
    end
    gamein_rst_nxt_s  = (state_nxt_s != PLAY);
    game_active_nxt_s = (state_nxt_s == PLAY);
  end

  // State, menu registers and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= MENU;
      game_r        <= 2'd0;
      choice_r      <= 2'd0;
      speed_r       <= SPD_DEF;
      launch_cnt_r  <= '0;
      vga_mux_r     <= VGAMUX_MENU;
      gamein_rst_r  <= 1'b1;
      game_active_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      game_r        <= game_nxt_s;
      choice_r      <= choice_nxt_s;
      speed_r       <= speed_nxt_s;
      launch_cnt_r  <= launch_cnt_nxt_s;
      vga_mux_r     <= vga_mux_nxt_s;
      gamein_rst_r  <= gamein_rst_nxt_s;
      game_active_r <= game_active_nxt_s;
    end
  end

`ifdef MENU_IDLE_TIMEOUT_EN
  // Menu idle counter; held at zero outside MENU by the next-state default.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_nxt_s;
    end
  end
`endif

  assign bus.vgaMUX       = vga_mux_r;
  assign bus.choice       = choice_r;
  assign bus.speedcontrol = speed_r;
  assign bus.gamein_rst   = gamein_rst_r;
  assign bus.game_active  = game_active_r;

endmodule

// File: tb/tb_game_menu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_menu_ctrl
// Purpose : self-checking bench for game_menu_ctrl; directed scenarios plus a
//           randomized key stream compared every cycle against a behavioural
//           model of the menu life cycle.
// ---------------------------------------------------------------------------
module tb_game_menu_ctrl;

  localparam int NUM_GAMES  = 2;
  localparam int RST_CYCLES = 16;
  localparam int SPEED_MIN  = 1;
  localparam int SPEED_MAX  = 15;
  localparam int SPEED_DEF  = 4;
  localparam int IDLE_CYC   = 100;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic k_up = 1'b0, k_down = 1'b0, k_left = 1'b0, k_right = 1'b0, k_start = 1'b0, k_exit = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  game_menu_ctrl_if bus ();
  assign bus.button_up    = k_up;
  assign bus.button_down  = k_down;
  assign bus.button_left  = k_left;
  assign bus.button_right = k_right;
  assign bus.start_btn    = k_start;
  assign bus.exit         = k_exit;

`ifdef MENU_IDLE_TIMEOUT_EN
  game_menu_ctrl #(.NUM_GAMES(NUM_GAMES), .RST_CYCLES(RST_CYCLES), .SPEED_MIN(SPEED_MIN),
                   .SPEED_MAX(SPEED_MAX), .SPEED_DEF(SPEED_DEF), .IDLE_CYCLES(IDLE_CYC))
    dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
`else
  game_menu_ctrl #(.NUM_GAMES(NUM_GAMES), .RST_CYCLES(RST_CYCLES), .SPEED_MIN(SPEED_MIN),
                   .SPEED_MAX(SPEED_MAX), .SPEED_DEF(SPEED_DEF))
    dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
`endif

  always #5 sys_clk = ~sys_clk;

  // Reference model: where the player is in the life cycle, in plain terms.
  int  m_where;        // 0 menu, 1 launching, 2 playing, 3 leaving
  int  m_choice, m_speed, m_game, m_launch_left, m_idle;
  bit  p_up, p_down, p_left, p_right, p_start;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_where = 0; m_choice = 0; m_speed = SPEED_DEF; m_game = 0;
    m_launch_left = 0; m_idle = 0;
    p_up = 0; p_down = 0; p_left = 0; p_right = 0; p_start = 0;
  endtask

  task automatic model_step();
    bit e_up, e_dn, e_l, e_r, e_s;
    e_up = k_up && !p_up;    e_dn = k_down && !p_down;
    e_l  = k_left && !p_left; e_r = k_right && !p_right;
    e_s  = k_start && !p_start;
    p_up = k_up; p_down = k_down; p_left = k_left; p_right = k_right; p_start = k_start;
    case (m_where)
      0: begin
        if (e_l && !e_r && m_speed > SPEED_MIN) m_speed--;
        if (e_r && !e_l && m_speed < SPEED_MAX) m_speed++;
        if (e_s) begin
          m_where = 1; m_game = m_choice; m_launch_left = RST_CYCLES; m_idle = 0;
        end else begin
          if (e_up && !e_dn) m_choice = (m_choice + NUM_GAMES - 1) % NUM_GAMES;
          if (e_dn && !e_up) m_choice = (m_choice + 1) % NUM_GAMES;
`ifdef MENU_IDLE_TIMEOUT_EN
          if (e_up || e_dn || e_l || e_r) m_idle = 0;
          else if (m_idle == IDLE_CYC - 1) begin m_choice = 0; m_idle = 0; end
          else m_idle++;
`endif
        end
      end
      1: begin
        if (k_exit) m_where = 0;
        else begin
          m_launch_left--;
          if (m_launch_left == 0) m_where = 2;
        end
      end
      2: if (k_exit) m_where = 3;
      default: m_where = 0;
    endcase
  endtask

  task automatic compare_all();
    int exp_vga;
    exp_vga = (m_where == 1 || m_where == 2) ? m_game + 1 : 0;
    check_eq("vgaMUX", int'(bus.vgaMUX), exp_vga);
    check_eq("choice", int'(bus.choice), m_choice);
    check_eq("speed", int'(bus.speedcontrol), m_speed);
    check_eq("gamein_rst", int'(bus.gamein_rst), (m_where == 2) ? 0 : 1);
    check_eq("game_active", int'(bus.game_active), (m_where == 2) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic pulse(input int key);
    case (key)
      0: k_up = 1'b1;
      1: k_down = 1'b1;
      2: k_left = 1'b1;
      3: k_right = 1'b1;
      default: k_start = 1'b1;
    endcase
    tick();
    k_up = 1'b0; k_down = 1'b0; k_left = 1'b0; k_right = 1'b0; k_start = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    // 1: reset values while held and after release.
    check_eq("rst_vga", int'(bus.vgaMUX), 0);
    check_eq("rst_choice", int'(bus.choice), 0);
    check_eq("rst_speed", int'(bus.speedcontrol), 4);
    check_eq("rst_gamein", int'(bus.gamein_rst), 1);
    check_eq("rst_active", int'(bus.game_active), 0);
    sys_rst_n = 1'b1;
    repeat (4) tick();

    // 2: wrap on up, held down steps once.
    pulse(0);
    check_eq("up_wrap", int'(bus.choice), 1);
    k_down = 1'b1;
    repeat (100) tick();
    k_down = 1'b0;
    tick();
    check_eq("down_held", int'(bus.choice), 0);

    // 3: speed saturation both ways and cancellation.
    repeat (12) pulse(3);
    check_eq("speed_max", int'(bus.speedcontrol), 15);
    repeat (20) pulse(2);
    check_eq("speed_min", int'(bus.speedcontrol), 1);
    k_left = 1'b1; k_right = 1'b1;
    tick();
    k_left = 1'b0; k_right = 1'b0;
    tick();
    check_eq("speed_lr", int'(bus.speedcontrol), 1);

    // 4: launch game 1, reset held for RST_CYCLES, then play.
    pulse(1);
    check_eq("choice1", int'(bus.choice), 1);
    k_start = 1'b1;
    for (int i = 0; i < RST_CYCLES; i++) begin
      tick();
      k_start = 1'b0;
      check_eq("launch_vga", int'(bus.vgaMUX), 2);
      check_eq("launch_rst", int'(bus.gamein_rst), 1);
    end
    tick();
    check_eq("play_rst", int'(bus.gamein_rst), 0);
    check_eq("play_active", int'(bus.game_active), 1);
    pulse(0);
    check_eq("play_ignore_up", int'(bus.choice), 1);

    // 5: exit for one cycle -> one leave cycle, then menu keeps choice.
    k_exit = 1'b1;
    tick();
    k_exit = 1'b0;
    check_eq("exit_vga", int'(bus.vgaMUX), 0);
    check_eq("exit_rst", int'(bus.gamein_rst), 1);
    check_eq("exit_active", int'(bus.game_active), 0);
    tick();
    check_eq("menu_choice", int'(bus.choice), 1);
    tick();
    check_eq("menu_stays", int'(bus.vgaMUX), 0);

    // 6a: abort during launch.
    k_start = 1'b1;
    tick();
    k_start = 1'b0;
    repeat (3) tick();
    k_exit = 1'b1;
    tick();
    k_exit = 1'b0;
    check_eq("abort_vga", int'(bus.vgaMUX), 0);
    repeat (20) tick();
    check_eq("abort_stay", int'(bus.game_active), 0);

    // 6b: asynchronous reset in the middle of play.
    pulse(4);
    repeat (RST_CYCLES + 2) tick();
    check_eq("pre_rst_play", int'(bus.game_active), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("arst_vga", int'(bus.vgaMUX), 0);
    check_eq("arst_choice", int'(bus.choice), 0);
    check_eq("arst_speed", int'(bus.speedcontrol), 4);
    check_eq("arst_gamein", int'(bus.gamein_rst), 1);
    check_eq("arst_active", int'(bus.game_active), 0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();

    // Idle behaviour with choice parked on entry 1.
    pulse(1);
    repeat (IDLE_CYC + 5) tick();
`ifdef MENU_IDLE_TIMEOUT_EN
    check_eq("idle_timeout", int'(bus.choice), 0);
`else
    check_eq("idle_keep", int'(bus.choice), 1);
`endif

    // Randomized key stream against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) k_up    = ~k_up;
      if ($urandom_range(0, 5) == 0) k_down  = ~k_down;
      if ($urandom_range(0, 4) == 0) k_left  = ~k_left;
      if ($urandom_range(0, 4) == 0) k_right = ~k_right;
      if ($urandom_range(0, 9) == 0) k_start = ~k_start;
      k_exit = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
